// File: rtl/pipeline_hazard_unit_if.sv
// Hazard-unit connection bundle: pre-decoded register fields and stage status
// coming from the datapath, stage enables/valids/forwarding selects and
// performance counters going back to it.
interface pipeline_hazard_unit_if #(
  parameter int AW    = 3,
  parameter int NSRC  = 2,
  parameter int CNT_W = 16
);
  // Datapath -> hazard unit
  logic                 fetch_valid;
  logic [NSRC*AW-1:0]   r_src;
  logic [NSRC-1:0]      r_src_use;
  logic [AW-1:0]        x_dst;
  logic [AW-1:0]        m_dst;
  logic [AW-1:0]        w_dst;
  logic                 x_we;
  logic                 m_we;
  logic                 w_we;
  logic                 x_is_load;
  logic                 br_taken;
  logic                 mem_wait;

  // Hazard unit -> datapath
  logic                 en_f;
  logic                 en_r;
  logic                 en_x;
  logic                 en_m;
  logic                 en_w;
  logic                 v_r;
  logic                 v_x;
  logic                 v_m;
  logic                 v_w;
  logic                 flush;
  logic [2*NSRC-1:0]    fwd_sel;
  logic [CNT_W-1:0]     stall_cnt;
  logic [CNT_W-1:0]     flush_cnt;

  // Datapath side
  modport master (
    output fetch_valid, r_src, r_src_use,
    output x_dst, m_dst, w_dst, x_we, m_we, w_we,
    output x_is_load, br_taken, mem_wait,
    input  en_f, en_r, en_x, en_m, en_w,
    input  v_r, v_x, v_m, v_w,
    input  flush, fwd_sel, stall_cnt, flush_cnt
  );

  // Hazard unit side
  modport slave (
    input  fetch_valid, r_src, r_src_use,
    input  x_dst, m_dst, w_dst, x_we, m_we, w_we,
    input  x_is_load, br_taken, mem_wait,
    output en_f, en_r, en_x, en_m, en_w,
    output v_r, v_x, v_m, v_w,
    output flush, fwd_sel, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipeline_hazard_unit.sv
// Hazard / forwarding controller for the 5-stage F/R/X/M/W pipeline.
// Tracks per-stage valid bits, inserts load-use bubbles, flushes on taken
// branches, freezes the front of the pipe while memory is busy, selects the
// forwarding source of every R-stage operand and counts stalls and flushes.
// The interface parameters must match AW/NSRC/CNT_W given here.
module pipeline_hazard_unit #(
  parameter int AW       = 3,
  parameter int NSRC     = 2,
  parameter int LOAD_LAT = 1,
  parameter int ZERO_REG = 0,
  parameter int CNT_W    = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  pipeline_hazard_unit_if.slave  hz
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  // Remaining load-use bubbles after the first one (LOAD_LAT is 1..3)
  localparam logic [1:0] LU_INIT = 2'(LOAD_LAT - 1);

  state_t            state;
  logic [1:0]        lu_cnt;
  logic              v_r;
  logic              v_x;
  logic              v_m;
  logic              v_w;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  logic [NSRC-1:0]   match_x;
  logic [NSRC-1:0]   match_m;
  logic [NSRC-1:0]   match_w;
  logic              x_load_q;
  logic              freeze;
  logic              branch;
  logic              lu_active;
  logic              lu_hazard;
  logic              en_f;
  logic              en_r;
  logic              en_x;
  logic              en_m;
  logic              en_w;
  logic              stall_now;
  logic [2*NSRC-1:0] fwd_sel;

  // A destination only counts when it is not the hard-wired zero register
  function automatic logic dst_ok(input logic [AW-1:0] dst);
    return !((ZERO_REG != 0) && (dst == '0));
  endfunction

  // Compare each R-stage source against the X/M/W destinations of valid writers
  always_comb begin
    match_x = '0;
    match_m = '0;
    match_w = '0;
    for (int k = 0; k < NSRC; k++) begin
      match_x[k] = hz.r_src_use[k] & v_x & hz.x_we &
                   (hz.r_src[k*AW +: AW] == hz.x_dst) & dst_ok(hz.x_dst);
      match_m[k] = hz.r_src_use[k] & v_m & hz.m_we &
                   (hz.r_src[k*AW +: AW] == hz.m_dst) & dst_ok(hz.m_dst);
      match_w[k] = hz.r_src_use[k] & v_w & hz.w_we &
                   (hz.r_src[k*AW +: AW] == hz.w_dst) & dst_ok(hz.w_dst);
    end
  end

  assign x_load_q = v_x & hz.x_is_load;

  // Youngest producer wins; a load in X has no data yet, so fall back to M/W
  always_comb begin
    fwd_sel = '0;
    for (int k = 0; k < NSRC; k++) begin
      if (match_x[k] && !x_load_q) begin
        fwd_sel[2*k +: 2] = 2'd1;
      end else if (match_m[k]) begin
        fwd_sel[2*k +: 2] = 2'd2;
      end else if (match_w[k]) begin
        fwd_sel[2*k +: 2] = 2'd3;
      end
    end
  end

  // Hazard priority: memory freeze, then branch flush, then load-use interlock
  always_comb begin
    freeze    = hz.mem_wait & v_m;
    branch    = hz.br_taken & v_x & ~freeze;
    lu_active = (state != RUN) & (lu_cnt != 2'd0) & ~freeze & ~branch;
    lu_hazard = v_r & x_load_q & (|match_x) & ~freeze & ~branch & ~lu_active;
  end

  // Stage enables follow the resolved hazard directly, same cycle
  always_comb begin
    en_f      = ~(freeze | lu_active | lu_hazard);
    en_r      = ~(freeze | lu_active | lu_hazard);
    en_x      = ~freeze;
    en_m      = ~freeze;
    en_w      = 1'b1;
    stall_now = ~en_f | ~en_r;
  end

  // Pipeline-control FSM, stage valid bits and saturating counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      lu_cnt    <= 2'd0;
      v_r       <= 1'b0;
      v_x       <= 1'b0;
      v_m       <= 1'b0;
      v_w       <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_now && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (branch && (flush_cnt != '1)) begin
        flush_cnt <= flush_cnt + CNT_W'(1);
      end

      if (freeze) begin
        // F..M hold; W retires and is refilled with a bubble
        state <= MEM_WAIT;
        v_w   <= 1'b0;
      end else if (branch) begin
        // Kill the wrong-path R and F instructions, branch moves on to M
        state  <= RUN;
        lu_cnt <= 2'd0;
        v_r    <= 1'b0;
        v_x    <= 1'b0;
        v_m    <= 1'b1;
        v_w    <= v_m;
      end else if (lu_active) begin
        // Further load-use bubbles while F/R hold
        state  <= LU_STALL;
        lu_cnt <= lu_cnt - 2'd1;
        v_x    <= 1'b0;
        v_m    <= v_x;
        v_w    <= v_m;
      end else if (lu_hazard) begin
        // First load-use bubble
        state  <= LU_STALL;
        lu_cnt <= LU_INIT;
        v_x    <= 1'b0;
        v_m    <= v_x;
        v_w    <= v_m;
      end else begin
        state <= RUN;
        v_r   <= hz.fetch_valid;
        v_x   <= v_r;
        v_m   <= v_x;
        v_w   <= v_m;
      end
    end
  end

  assign hz.en_f      = en_f;
  assign hz.en_r      = en_r;
  assign hz.en_x      = en_x;
  assign hz.en_m      = en_m;
  assign hz.en_w      = en_w;
  assign hz.v_r       = v_r;
  assign hz.v_x       = v_x;
  assign hz.v_m       = v_m;
  assign hz.v_w       = v_w;
  assign hz.flush     = branch;
  assign hz.fwd_sel   = fwd_sel;
  assign hz.stall_cnt = stall_cnt;
  assign hz.flush_cnt = flush_cnt;

endmodule
